alu_sequencer: RTL

- Multi-cycle sequencer for the 16-bit signed ALU datapath: add, sub, mul, div, mod.
- Accepts one operation at a time over a valid/ready request channel.
- Add, sub and mul complete in one execute cycle. Div and mod run an iterative restoring divider over WIDTH cycles.
- Returns a 32-bit result plus a 2-bit error code over a valid/ready response channel.
- Replaces the combinational loop-based divider path in the breadboard ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_sequencer_if.sv | 27 ++
 rtl/div_core.sv | 86 ++++++++
 rtl/alu_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM state
// encoding and error codes.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_DIV0  = 2'b10;
    localparam logic [1:0] ERR_BADOP = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        DIV,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response channel of the ALU sequencer.
//   op_valid/op_ready/op_code/input1/input2  : request (master -> slave)
//   result_valid/result_ready/output1/err_code : response (slave -> master)
interface alu_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
);
    logic                 op_valid;
    logic                 op_ready;
    logic [3:0]           op_code;
    logic [WIDTH-1:0]     input1;
    logic [WIDTH-1:0]     input2;
    logic                 result_valid;
    logic                 result_ready;
    logic [OUT_WIDTH-1:0] output1;
    logic [1:0]           err_code;

    modport master (
        output op_valid, op_code, input1, input2, result_ready,
        input  op_ready, result_valid, output1, err_code
    );

    modport slave (
        input  op_valid, op_code, input1, input2, result_ready,
        output op_ready, result_valid, output1, err_code
    );
endinterface

// File: rtl/div_core.sv
// Unsigned iterative restoring divider, one quotient bit per cycle,
// WIDTH cycles per operation.
//   clk, reset           : clock, synchronous active-high reset
//   start                : load operands and begin (ignored while busy)
//   dividend, divisor    : WIDTH+1-bit magnitudes, dividend <= 2^(WIDTH-1)
//   busy                 : operation in progress
//   done                 : high during the cycle of the final step
//   quotient, remainder  : magnitudes, valid after done
module div_core #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [WIDTH:0] dividend,
    input  logic [WIDTH:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:0] quotient,
    output logic [WIDTH:0] remainder
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   quo_q, quo_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;

    assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH]};
    assign trial  = {1'b0, rem_sh} - {1'b0, dvs_q};
    assign done   = busy_q && (cnt_q == CNT_LAST);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (start && !busy_q) begin
            // The dividend top bit is always 0 (magnitude <= 2^(WIDTH-1)),
            // so its quotient step is pre-applied: it starts in the
            // remainder and the quotient register shifts in WIDTH new bits.
            busy_d = 1'b1;
            cnt_d  = '0;
            dvs_d  = divisor;
            rem_d  = {{WIDTH{1'b0}}, dividend[WIDTH]};
            quo_d  = {dividend[WIDTH-1:0], 1'b0};
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (!trial[WIDTH+1]) begin
                rem_d = trial[WIDTH:0];
                quo_d = {quo_q[WIDTH-1:0], 1'b1};
            end else begin
                rem_d = rem_sh;
                quo_d = {quo_q[WIDTH-1:0], 1'b0};
            end
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the signed ALU: add/sub/mul in one execute
// cycle, div/mod through the iterative divider, one operation in flight.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of the request/response channel
//
// state | meaning
// IDLE  | waiting for a request, op_ready high
// EXEC  | compute add/sub/mul/errors, or launch the divider
// DIV   | divider iterating, WIDTH cycles
// FIX   | apply quotient/remainder signs
// DONE  | result presented until result_ready
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    localparam int EXT = OUT_WIDTH - WIDTH;

    state_e               state_q, state_d;
    logic [3:0]           op_code_q, op_code_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [OUT_WIDTH-1:0] output1_q, output1_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 result_valid_q, result_valid_d;

    logic signed [OUT_WIDTH-1:0] a_sx, b_sx, sum, dif, prod;
    logic [WIDTH:0]              a_mag, b_mag, div_quo, div_rem;
    logic [OUT_WIDTH-1:0]        quo_ext, rem_ext, quo_s, rem_s;
    logic                        div_start, div_busy, div_done;

    // True when the upper bits are not a pure sign extension of bit WIDTH-1.
    function automatic logic out_of_range(input logic [EXT:0] hi);
        return !((&hi) || !(|hi));
    endfunction

    assign a_sx  = {{EXT{a_q[WIDTH-1]}}, a_q};
    assign b_sx  = {{EXT{b_q[WIDTH-1]}}, b_q};
    assign sum   = a_sx + b_sx;
    assign dif   = a_sx - b_sx;
    assign prod  = a_sx * b_sx;
    // One extra bit so that the most negative operand has a magnitude.
    assign a_mag = a_q[WIDTH-1] ? -{1'b1, a_q} : {1'b0, a_q};
    assign b_mag = b_q[WIDTH-1] ? -{1'b1, b_q} : {1'b0, b_q};

    assign quo_ext = {{(EXT-1){1'b0}}, div_quo};
    assign rem_ext = {{(EXT-1){1'b0}}, div_rem};
    assign quo_s   = q_neg_q ? -quo_ext : quo_ext;
    assign rem_s   = r_neg_q ? -rem_ext : rem_ext;

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d        = state_q;
        op_code_d      = op_code_q;
        a_d            = a_q;
        b_d            = b_q;
        q_neg_d        = q_neg_q;
        r_neg_d        = r_neg_q;
        output1_d      = output1_q;
        err_code_d     = err_code_q;
        result_valid_d = result_valid_q;
        div_start      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.op_valid && bus.op_ready) begin
                    op_code_d = bus.op_code;
                    a_d       = bus.input1;
                    b_d       = bus.input2;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d    = DONE;
                err_code_d = ERR_NONE;
                case (op_code_q)
                    OP_ADD: begin
                        output1_d  = sum;
                        err_code_d = out_of_range(sum[OUT_WIDTH-1:WIDTH-1]) ? ERR_OVF : ERR_NONE;
                    end
                    OP_SUB: begin
                        output1_d  = dif;
                        err_code_d = out_of_range(dif[OUT_WIDTH-1:WIDTH-1]) ? ERR_OVF : ERR_NONE;
                    end
                    OP_MUL: begin
                        output1_d = prod;
                    end
                    OP_DIV, OP_MOD: begin
                        if (b_q == '0) begin
                            output1_d  = '0;
                            err_code_d = ERR_DIV0;
                        end else begin
                            div_start = 1'b1;
                            q_neg_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                            r_neg_d   = a_q[WIDTH-1];
                            state_d   = DIV;
                        end
                    end
                    default: begin
                        output1_d  = '0;
                        err_code_d = ERR_BADOP;
                    end
                endcase
            end
            DIV: begin
                if (div_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                output1_d  = (op_code_q == OP_DIV) ? quo_s : rem_s;
                err_code_d = ERR_NONE;
                state_d    = DONE;
            end
            DONE: begin
                // result_valid rises one cycle after entering DONE, and
                // retirement needs it already high.
                if (result_valid_q && bus.result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_code_q      <= '0;
            a_q            <= '0;
            b_q            <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            output1_q      <= '0;
            err_code_q     <= ERR_NONE;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_code_q      <= op_code_d;
            a_q            <= a_d;
            b_q            <= b_d;
            q_neg_q        <= q_neg_d;
            r_neg_q        <= r_neg_d;
            output1_q      <= output1_d;
            err_code_q     <= err_code_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.op_ready     = (state_q == IDLE) && !div_busy && !reset;
    assign bus.result_valid = result_valid_q;
    assign bus.output1      = output1_q;
    assign bus.err_code     = err_code_q;
endmodule
